// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the ram BIST initiator: FSM states, LFSR taps
// and the address-derived fill pattern.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    VERIFY,
    RAND,
    DONE
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, taps on state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fill pattern before truncation to the data width: 2*a
  function automatic logic [31:0] pattern(input logic [31:0] a);
    return a << 1;
  endfunction

endpackage

// File: rtl/ram_bist_lfsr.sv
// 16-bit Fibonacci LFSR used to generate random read addresses; reloads its
// seed on load and steps once per enabled cycle.
module ram_bist_lfsr
  import ram_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'd35
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  output logic [15:0] state
);

  logic fb;

  assign fb = ^(state & LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[14:0], fb};
    end
  end

endmodule

// File: rtl/ram_bist.sv
// Fill/readback BIST initiator for a single-port ram: writes P(a) everywhere,
// reads it back sequentially and at LFSR addresses, and records mismatches.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 8,
  parameter int          READ_LAT = 1,
  parameter int          NUM_RAND = 20,
  parameter logic [15:0] SEED     = 16'd35
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              ram_write,
  output logic              ram_select,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [2:0]        LAST_DRAIN = 3'(READ_LAT - 1);
  localparam logic [31:0]       LAST_RAND  = 32'(NUM_RAND - 1);

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'(pattern(32'(a)));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       rcnt_q, rcnt_d;
  logic              drain_q, drain_d;
  logic [2:0]        dcnt_q, dcnt_d;
  logic              start_acc;
  logic              issue;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       lfsr_state;
  logic              lfsr_unused;
  logic              mism;

  logic              vld_p  [READ_LAT];
  logic [ADDR_W-1:0] addr_p [READ_LAT];
  logic [DATA_W-1:0] exp_p  [READ_LAT];

  ram_bist_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (reset),
    .load  (start_acc),
    .en    (issue && (state_q == RAND)),
    .state (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state[15:ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      drain_q <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      drain_q <= drain_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Each read phase issues its reads, then idles READ_LAT cycles so every
  // outstanding compare lands before the phase hands over.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    drain_d   = drain_q;
    dcnt_d    = dcnt_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = FILL;
          cnt_d     = '0;
        end
      end
      FILL: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) state_d = VERIFY;
      end
      VERIFY: begin
        if (!drain_q) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_ADDR) begin
            drain_d = 1'b1;
            dcnt_d  = '0;
          end
        end else if (dcnt_q == LAST_DRAIN) begin
          drain_d = 1'b0;
          rcnt_d  = '0;
          state_d = (NUM_RAND == 0) ? DONE : RAND;
        end else begin
          dcnt_d = dcnt_q + 3'd1;
        end
      end
      RAND: begin
        if (!drain_q) begin
          rcnt_d = rcnt_q + 32'd1;
          if (rcnt_q == LAST_RAND) begin
            drain_d = 1'b1;
            dcnt_d  = '0;
          end
        end else if (dcnt_q == LAST_DRAIN) begin
          drain_d = 1'b0;
          state_d = DONE;
        end else begin
          dcnt_d = dcnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue       = ((state_q == VERIFY) || (state_q == RAND)) && !drain_q;
    rd_addr     = (state_q == VERIFY) ? cnt_q : lfsr_state[ADDR_W-1:0];
    ram_select  = (state_q == FILL) || issue;
    ram_write   = (state_q == FILL);
    ram_address = '0;
    ram_data_in = '0;
    if (state_q == FILL) begin
      ram_address = cnt_q;
      ram_data_in = pat(cnt_q);
    end else if (issue) begin
      ram_address = rd_addr;
    end
    busy = (state_q == FILL) || (state_q == VERIFY) || (state_q == RAND);
    done = (state_q == DONE);
    pass = done && (err_count == '0);
  end

  // Issue -> compare: address and expected data travel READ_LAT stages with
  // the read so they line up with ram_data_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_p[0] <= rd_addr;
    exp_p[0]  <= pat(rd_addr);
    for (int i = 1; i < READ_LAT; i++) begin
      addr_p[i] <= addr_p[i-1];
      exp_p[i]  <= exp_p[i-1];
    end
  end

  // Compare stage: a zero count marks the first mismatch of the run.
  assign mism = vld_p[READ_LAT-1] && (ram_data_out != exp_p[READ_LAT-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (start_acc) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mism) begin
      err_count <= sat_inc(err_count);
      if (err_count == '0) begin
        first_err_addr <= addr_p[READ_LAT-1];
        first_err_data <= ram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: two instances (READ_LAT=1/NUM_RAND=20 and
// READ_LAT=3/NUM_RAND=0) against behavioural ram models and a read-sequence model.
module tb_ram_bist;

  localparam int DEPTH = 1024;
  localparam int NR    = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;

  logic [9:0] a_addr, a_fa, b_addr, b_fa;
  logic [7:0] a_din, a_dout, a_fd, b_din, b_dout, b_fd;
  logic       a_wr, a_sel, a_busy, a_done, a_pass;
  logic       b_wr, b_sel, b_busy, b_done, b_pass;
  logic [15:0] a_err, b_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_bist #(.ADDR_W(10), .DATA_W(8), .READ_LAT(1), .NUM_RAND(NR), .SEED(16'd35)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .ram_address(a_addr), .ram_data_in(a_din), .ram_data_out(a_dout),
    .ram_write(a_wr), .ram_select(a_sel), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .first_err_addr(a_fa), .first_err_data(a_fd)
  );

  ram_bist #(.ADDR_W(10), .DATA_W(8), .READ_LAT(3), .NUM_RAND(0), .SEED(16'd35)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .ram_address(b_addr), .ram_data_in(b_din), .ram_data_out(b_dout),
    .ram_write(b_wr), .ram_select(b_sel), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .first_err_addr(b_fa), .first_err_data(b_fd)
  );

  // Ram models; ovr_* emulates locations corrupted after the fill.
  logic [7:0] mem_a [DEPTH];
  logic [7:0] mem_b [DEPTH];
  bit         ovr_en  [DEPTH];
  logic [7:0] ovr_val [DEPTH];
  logic [7:0] b_q1, b_q2;

  always @(posedge clk) begin
    if (a_sel && a_wr) mem_a[a_addr] <= a_din;
    if (a_sel && !a_wr) a_dout <= ovr_en[a_addr] ? ovr_val[a_addr] : mem_a[a_addr];
  end

  always @(posedge clk) begin
    if (b_sel && b_wr) mem_b[b_addr] <= b_din;
    if (b_sel && !b_wr) b_q1 <= mem_b[b_addr];
    b_q2   <= b_q1;
    b_dout <= b_q2;
  end

  function automatic logic [7:0] exp_pat(input logic [9:0] a);
    return 8'((2 * int'(a)) % 256);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
    return {s[14:0], fb};
  endfunction

  logic [9:0] rd_q [$];
  int wr_cnt, wr_bad, b_rd_cnt, b_wr_cnt;

  always @(negedge clk) begin
    if (a_sel && !a_wr) rd_q.push_back(a_addr);
    if (a_sel && a_wr) begin
      wr_cnt++;
      if (a_din !== exp_pat(a_addr)) wr_bad++;
    end
    if (b_sel && !b_wr) b_rd_cnt++;
    if (b_sel && b_wr) b_wr_cnt++;
  end

  // Expected outcome of one run of dut_a from the read order and ram contents.
  task automatic model(output int err, output int fa, output int fd);
    logic [15:0] s;
    logic [9:0]  a;
    logic [7:0]  v;
    s = 16'd35; err = 0; fa = 0; fd = 0;
    for (int i = 0; i < DEPTH + NR; i++) begin
      if (i < DEPTH) a = 10'(i);
      else begin
        a = s[9:0];
        s = lfsr_step(s);
      end
      v = ovr_en[a] ? ovr_val[a] : exp_pat(a);
      if (v != exp_pat(a)) begin
        if (err == 0) begin
          fa = int'(a);
          fd = int'(v);
        end
        err++;
      end
    end
  endtask

  task automatic clear_ovr();
    for (int i = 0; i < DEPTH; i++) ovr_en[i] = 1'b0;
  endtask

  task automatic run_a(input bit spam, output int n);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    total++;
    if (a_busy !== 1'b1 || a_done !== 1'b0 || a_pass !== 1'b0 || a_err !== 16'd0 || a_fa !== 10'd0 || a_fd !== 8'd0) begin
      bad++;
      $display("FAIL start_clear: busy=%b done=%b pass=%b err=%0d fa=%0d fd=%0d, want busy=1 done=0 pass=0 err=0 fa=0 fd=0",
               a_busy, a_done, a_pass, a_err, a_fa, a_fd);
    end
    n = 0;
    while (n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (a_done === 1'b1) break;
      start_a = spam && (n == 2069 || $urandom_range(0, 39) == 0);
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a_sel, a_wr, a_addr, a_din, a_busy, a_done, a_pass, a_err, a_fa, a_fd} !== '0) begin
      bad++;
      $display("FAIL reset_a: outputs=%h want 0", {a_sel, a_wr, a_addr, a_din, a_busy, a_done, a_pass, a_err, a_fa, a_fd});
    end
    total++;
    if ({b_sel, b_wr, b_addr, b_din, b_busy, b_done, b_pass, b_err, b_fa, b_fd} !== '0) begin
      bad++;
      $display("FAIL reset_b: outputs=%h want 0", {b_sel, b_wr, b_addr, b_din, b_busy, b_done, b_pass, b_err, b_fa, b_fd});
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({a_busy, a_done, a_sel} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: busy,done,sel=%b want 000", {a_busy, a_done, a_sel});
    end
  endtask

  task automatic test_fill_verify();
    int n, base, w0, wb0, seq_bad;
    logic [15:0] s;
    clear_ovr();
    base = rd_q.size(); w0 = wr_cnt; wb0 = wr_bad;
    run_a(1'b0, n);
    total++;
    if (n != 2070) begin bad++; $display("FAIL fv_cycles: got=%0d want=2070", n); end
    total++;
    if (wr_cnt - w0 != DEPTH || wr_bad - wb0 != 0) begin
      bad++; $display("FAIL fv_writes: count=%0d badvals=%0d want 1024/0", wr_cnt - w0, wr_bad - wb0);
    end
    total++;
    if (mem_a[5] !== 8'd10 || mem_a[200] !== 8'd144) begin
      bad++; $display("FAIL fv_mem: ram[5]=%0d ram[200]=%0d want 10/144", mem_a[5], mem_a[200]);
    end
    total++;
    if (rd_q.size() - base != DEPTH + NR) begin
      bad++; $display("FAIL fv_reads: got=%0d want=%0d", rd_q.size() - base, DEPTH + NR);
    end
    seq_bad = 0;
    for (int i = 0; i < DEPTH; i++) if (rd_q[base + i] !== 10'(i)) seq_bad++;
    total++;
    if (seq_bad != 0) begin bad++; $display("FAIL fv_seq_order: wrong=%0d want 0", seq_bad); end
    s = 16'd35;
    for (int j = 0; j < NR; j++) begin
      total++;
      if (rd_q[base + DEPTH + j] !== s[9:0]) begin
        bad++; $display("FAIL fv_rand_addr[%0d]: got=%0d want=%0d", j, rd_q[base + DEPTH + j], s[9:0]);
      end
      s = lfsr_step(s);
    end
    total++;
    if ({a_err, a_fa, a_fd, a_pass, a_done, a_busy} !== {16'd0, 10'd0, 8'd0, 3'b110}) begin
      bad++; $display("FAIL fv_result: err=%0d fa=%0d fd=%0d pass=%b done=%b busy=%b want 0 0 0 1 1 0",
                      a_err, a_fa, a_fd, a_pass, a_done, a_busy);
    end
  endtask

  task automatic check_errs(input string name, input int n);
    int e, fa, fd;
    model(e, fa, fd);
    total++;
    if (n != 2070) begin bad++; $display("FAIL %s_cycles: got=%0d want=2070", name, n); end
    total++;
    if ({a_err, a_fa, a_fd, a_pass} !== {16'(e), 10'(fa), 8'(fd), (e == 0)}) begin
      bad++; $display("FAIL %s_result: err=%0d fa=%0d fd=%0d pass=%b want %0d %0d %0d %b",
                      name, a_err, a_fa, a_fd, a_pass, e, fa, fd, (e == 0));
    end
  endtask

  task automatic test_single_err();
    int n;
    clear_ovr();
    ovr_en[300] = 1'b1; ovr_val[300] = 8'h00;
    run_a(1'b0, n);
    check_errs("single", n);
    total++;
    if (a_fa !== 10'd300 || a_fd !== 8'd0 || a_pass !== 1'b0) begin
      bad++; $display("FAIL single_first: fa=%0d fd=%0d pass=%b want 300 0 0", a_fa, a_fd, a_pass);
    end
  endtask

  task automatic test_two_err();
    int n;
    clear_ovr();
    ovr_en[7]   = 1'b1; ovr_val[7]   = exp_pat(10'd7)   ^ 8'($urandom_range(1, 255));
    ovr_en[900] = 1'b1; ovr_val[900] = exp_pat(10'd900) ^ 8'($urandom_range(1, 255));
    run_a(1'b0, n);
    check_errs("two", n);
    total++;
    if (a_fa !== 10'd7 || a_fd !== ovr_val[7]) begin
      bad++; $display("FAIL two_first: fa=%0d fd=%0d want 7 %0d", a_fa, a_fd, ovr_val[7]);
    end
  endtask

  task automatic test_random_err();
    int n, k;
    logic [9:0] a;
    for (int it = 0; it < 2; it++) begin
      clear_ovr();
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        a = 10'($urandom_range(0, DEPTH - 1));
        ovr_en[a] = 1'b1; ovr_val[a] = 8'($urandom);
      end
      run_a(1'b0, n);
      check_errs("rand", n);
    end
  endtask

  task automatic test_reset_mid();
    int n, w0;
    bit seen;
    clear_ovr();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (a_sel === 1'b1 && a_wr === 1'b0 && a_addr === 10'd512) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mid_reach512: seen=0 want 1"); end
    reset = 1'b1;
    #1;
    total++;
    if ({a_sel, a_wr, a_addr, a_din, a_busy, a_done, a_pass, a_err} !== '0) begin
      bad++; $display("FAIL mid_async: outputs=%h want 0", {a_sel, a_wr, a_addr, a_din, a_busy, a_done, a_pass, a_err});
    end
    w0 = wr_cnt;
    @(posedge clk); #1;
    total++;
    if ({a_sel, a_busy, a_done} !== 3'b000 || wr_cnt != w0) begin
      bad++; $display("FAIL mid_held: sel,busy,done=%b writes=%0d want 000 0", {a_sel, a_busy, a_done}, wr_cnt - w0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_a(1'b0, n);
    check_errs("mid_rerun", n);
  endtask

  task automatic test_back_to_back();
    int n, base, lbad;
    logic [9:0]  a;
    logic [15:0] s;
    clear_ovr();
    a = 10'($urandom_range(0, DEPTH - 1));
    ovr_en[a] = 1'b1; ovr_val[a] = exp_pat(a) ^ 8'($urandom_range(1, 255));
    run_a(1'b1, n);
    check_errs("spam", n);
    @(posedge clk); #1;
    total++;
    if (a_done !== 1'b1 || a_busy !== 1'b0) begin
      bad++; $display("FAIL spam_last_start: done=%b busy=%b want 1 0", a_done, a_busy);
    end
    clear_ovr();
    base = rd_q.size();
    run_a(1'b0, n);
    check_errs("restart", n);
    s = 16'd35; lbad = 0;
    for (int j = 0; j < NR; j++) begin
      if (rd_q[base + DEPTH + j] !== s[9:0]) lbad++;
      s = lfsr_step(s);
    end
    total++;
    if (rd_q[base + DEPTH] !== 10'd35 || lbad != 0) begin
      bad++; $display("FAIL restart_lfsr: first=%0d wrong=%0d want 35 0", rd_q[base + DEPTH], lbad);
    end
  endtask

  task automatic test_lat3_norand();
    int n, r0, w0;
    r0 = b_rd_cnt; w0 = b_wr_cnt;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (b_done === 1'b1) break;
    end
    total++;
    if (n != 2051) begin bad++; $display("FAIL lat3_cycles: got=%0d want=2051", n); end
    total++;
    if ({b_err, b_fa, b_fd, b_pass, b_busy} !== {16'd0, 10'd0, 8'd0, 2'b10}) begin
      bad++; $display("FAIL lat3_result: err=%0d fa=%0d fd=%0d pass=%b busy=%b want 0 0 0 1 0",
                      b_err, b_fa, b_fd, b_pass, b_busy);
    end
    total++;
    if (b_rd_cnt - r0 != DEPTH || b_wr_cnt - w0 != DEPTH) begin
      bad++; $display("FAIL lat3_access: reads=%0d writes=%0d want 1024 1024", b_rd_cnt - r0, b_wr_cnt - w0);
    end
    total++;
    if (mem_b[5] !== 8'd10 || mem_b[1023] !== 8'd254) begin
      bad++; $display("FAIL lat3_mem: ram[5]=%0d ram[1023]=%0d want 10 254", mem_b[5], mem_b[1023]);
    end
  endtask

  initial begin
    test_reset();
    test_fill_verify();
    test_single_err();
    test_two_err();
    test_random_err();
    test_reset_mid();
    test_back_to_back();
    test_lat3_norand();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
